vline_buf: RTL and testbench

Parametrised double-buffered video line buffer between the memory-fetch path and the video-output scanner. The fetch side writes one line of DATA_W-bit words into the back bank. The scanner swaps banks at start of line and reads 2×DATA_W-bit pairs by column from the front bank. Adds ping-pong banking, a write-side ready handshake, overflow and underrun detection, and optional blanking on underrun. Single clock: memory and scanner share one domain.

---
 rtl/vline_buf.sv | 106 ++++++++++
 tb/tb_vline_buf.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vline_buf.sv
// Ping-pong video line buffer: fetch side fills the back bank word by word; scanner swaps and reads word pairs from the front bank.
// Optional VLINE_BUF_BLANK_EN: a failed swap invalidates the front line and blanks the read data until the next good swap.
module vline_buf #(
  parameter int DATA_W     = 16,
  parameter int WORDS_LOG2 = 7
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wr_valid,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_wr_sol,
  input  logic                    i_wr_eol,
  output logic                    o_wr_ready,
  input  logic                    i_rd_swap,
  input  logic [WORDS_LOG2-2:0]   i_rd_col,
  output logic [2*DATA_W-1:0]     o_rd_data,
  output logic                    o_line_valid,
  input  logic                    i_clr_status,
  output logic                    o_ovf,
  output logic                    o_underrun
);

  localparam int DEPTH = 1 << WORDS_LOG2;

  // Flat storage, addressed as {bank, word}.
  logic [DATA_W-1:0]   mem_q [2*DEPTH];

  logic                rb_q, rb_d;
  logic                bfull_q, bfull_d;
  logic [WORDS_LOG2:0] wp_q, wp_d;
  logic [2*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                line_valid_q, line_valid_d;
  logic                ovf_q, ovf_d;
  logic                underrun_q, underrun_d;

  logic [WORDS_LOG2:0] wp_base;
  logic                wr_en, wr_drop, eol_acc, eol_drop, swap_ok, swap_fail;
  logic [WORDS_LOG2:0] rd_addr_even, rd_addr_odd, wr_addr;

  always_comb begin
    wp_base      = i_wr_sol ? '0 : wp_q;
    wr_en        = i_wr_valid && !bfull_q && !wp_base[WORDS_LOG2];
    wr_drop      = i_wr_valid && !wr_en;
    eol_acc      = i_wr_eol && !bfull_q;
    eol_drop     = i_wr_eol && bfull_q;
    // An eol landing on the same edge counts as a full back bank for the swap.
    swap_ok      = i_rd_swap && (bfull_q || eol_acc);
    swap_fail    = i_rd_swap && !swap_ok;
    wr_addr      = {~rb_q, wp_base[WORDS_LOG2-1:0]};
    rd_addr_even = {rb_q, i_rd_col, 1'b0};
    rd_addr_odd  = {rb_q, i_rd_col, 1'b1};

    wp_d         = eol_acc ? '0 : wp_base + {{WORDS_LOG2{1'b0}}, wr_en};
    bfull_d      = swap_ok ? 1'b0 : (eol_acc ? 1'b1 : bfull_q);
    rb_d         = swap_ok ? ~rb_q : rb_q;
    rd_data_d    = {mem_q[rd_addr_odd], mem_q[rd_addr_even]};

    line_valid_d = line_valid_q;
    if (swap_ok)
      line_valid_d = 1'b1;
`ifdef VLINE_BUF_BLANK_EN
    else if (swap_fail)
      line_valid_d = 1'b0;
`endif

    ovf_d      = (wr_drop || eol_drop) ? 1'b1 : (i_clr_status ? 1'b0 : ovf_q);
    underrun_d = swap_fail ? 1'b1 : (i_clr_status ? 1'b0 : underrun_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rb_q         <= 1'b0;
      bfull_q      <= 1'b0;
      wp_q         <= '0;
      rd_data_q    <= '0;
      line_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      rb_q         <= rb_d;
      bfull_q      <= bfull_d;
      wp_q         <= wp_d;
      rd_data_q    <= rd_data_d;
      line_valid_q <= line_valid_d;
      ovf_q        <= ovf_d;
      underrun_q   <= underrun_d;
    end
  end

  // Memory has no reset; reset only discards the banks logically.
  always_ff @(posedge i_clk) begin
    if (!i_reset && wr_en)
      mem_q[wr_addr] <= i_wr_data;
  end

  assign o_wr_ready   = !bfull_q;
  assign o_line_valid = line_valid_q;
  assign o_ovf        = ovf_q;
  assign o_underrun   = underrun_q;
`ifdef VLINE_BUF_BLANK_EN
  assign o_rd_data    = line_valid_q ? rd_data_q : '0;
`else
  assign o_rd_data    = rd_data_q;
`endif

endmodule

// File: tb/tb_vline_buf.sv
// Scoreboard bench for vline_buf: reads push expected pairs, a negedge monitor pops and compares.
module tb_vline_buf;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_sol, wr_eol, rd_swap, clr;
  logic [15:0] wr_data;
  logic [5:0]  rd_col;
  logic        wr_ready, line_valid, ovf, underrun;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic        rd_issue = 1'b0;
  logic        rd_vld   = 1'b0;

  vline_buf #(.DATA_W(16), .WORDS_LOG2(7)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_wr_sol(wr_sol), .i_wr_eol(wr_eol),
    .o_wr_ready(wr_ready),
    .i_rd_swap(rd_swap), .i_rd_col(rd_col), .o_rd_data(rd_data),
    .o_line_valid(line_valid), .i_clr_status(clr),
    .o_ovf(ovf), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= rd_issue;

  always @(negedge clk) begin
    if (rd_vld) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: got=%h but no expected entry queued", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          bad++;
          $display("FAIL rd_data: got=%h exp=%h", rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] d, input logic sol, input logic eol, input logic swap);
    wr_valid = 1'b1; wr_data = d; wr_sol = sol; wr_eol = eol; rd_swap = swap;
    tick;
    wr_valid = 1'b0; wr_sol = 1'b0; wr_eol = 1'b0; rd_swap = 1'b0;
  endtask

  task automatic line(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) wr(base + 16'(i), i == 0, 1'b0, 1'b0);
  endtask

  task automatic eol;
    wr_eol = 1'b1; tick; wr_eol = 1'b0;
  endtask

  task automatic swap;
    rd_swap = 1'b1; tick; rd_swap = 1'b0;
  endtask

  task automatic clear;
    clr = 1'b1; tick; clr = 1'b0;
  endtask

  task automatic rd(input int c, input logic [31:0] exp);
    rd_col = 6'(c); rd_issue = 1'b1;
    exp_q.push_back(exp);
    tick;
    rd_issue = 1'b0;
    tick;
  endtask

  function automatic logic [31:0] pair(input logic [15:0] base, input int c);
    logic [15:0] lo;
    lo = base + 16'(2 * c);
    return {lo + 16'd1, lo};
  endfunction

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_sol = 1'b0; wr_eol = 1'b0; rd_swap = 1'b0;
    clr = 1'b0; wr_data = '0; rd_col = '0;
    tick; tick;
    rst = 1'b0;
    check("reset wr_ready", 32'(wr_ready), 32'd1);
    check("reset line_valid", 32'(line_valid), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    check("reset rd_data", rd_data, 32'd0);

    // Basic line 0x0000..0x007F
    line(16'h0000, 128);
    check("wr_ready before eol", 32'(wr_ready), 32'd1);
    eol;
    check("wr_ready after eol", 32'(wr_ready), 32'd0);
    swap;
    check("line_valid after swap", 32'(line_valid), 32'd1);
    check("wr_ready after swap", 32'(wr_ready), 32'd1);
    for (int k = 0; k < 64; k++) rd(k, pair(16'h0000, k));
    check("ovf line1", 32'(ovf), 32'd0);
    check("underrun line1", 32'(underrun), 32'd0);

    // Write into a full back bank
    line(16'h0100, 128);
    eol;
    wr(16'hDEAD, 1'b0, 1'b0, 1'b0);
    check("ovf full-bank write", 32'(ovf), 32'd1);
    check("wr_ready full", 32'(wr_ready), 32'd0);
    clear;
    check("ovf cleared", 32'(ovf), 32'd0);
    swap;
    rd(0, pair(16'h0100, 0));
    rd(63, pair(16'h0100, 63));

    // Overlong line: words 128 and 129 dropped
    line(16'h0200, 130);
    check("ovf long line", 32'(ovf), 32'd1);
    eol;
    swap;
    rd(0, pair(16'h0200, 0));
    rd(63, pair(16'h0200, 63));
    clear;

    // Swap with an empty back bank
    swap;
    check("underrun set", 32'(underrun), 32'd1);
`ifdef VLINE_BUF_BLANK_EN
    check("line_valid after underrun", 32'(line_valid), 32'd0);
    rd(5, 32'd0);
`else
    check("line_valid after underrun", 32'(line_valid), 32'd1);
    rd(5, pair(16'h0200, 5));
`endif
    clear;
    check("underrun cleared", 32'(underrun), 32'd0);

    // Final word, eol and swap on the same edge
    line(16'h0300, 127);
    wr(16'h037F, 1'b0, 1'b1, 1'b1);
    check("wr_ready eol+swap", 32'(wr_ready), 32'd1);
    check("line_valid eol+swap", 32'(line_valid), 32'd1);
    check("underrun eol+swap", 32'(underrun), 32'd0);
    rd(63, pair(16'h0300, 63));
    rd(0, pair(16'h0300, 0));

    // Reset mid-line with a full back bank and sticky flags set
    line(16'h0400, 128);
    eol;
    wr(16'hBEEF, 1'b0, 1'b0, 1'b0);
    check("ovf before reset", 32'(ovf), 32'd1);
    rst = 1'b1; wr_valid = 1'b1; wr_data = 16'h1234;
    tick;
    rst = 1'b0; wr_valid = 1'b0;
    check("post-reset wr_ready", 32'(wr_ready), 32'd1);
    check("post-reset line_valid", 32'(line_valid), 32'd0);
    check("post-reset rd_data", rd_data, 32'd0);
    check("post-reset ovf", 32'(ovf), 32'd0);
    check("post-reset underrun", 32'(underrun), 32'd0);

    tick; tick;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
